// File: rtl/edge_event_capture_if.sv
// Edge capture bus: event pulses and enables in; sticky status, clear handshake and counter readback out.
interface edge_event_capture_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
);
  logic [WIDTH-1:0] pos;
  logic [WIDTH-1:0] neg;
  logic [WIDTH-1:0] pos_en;
  logic [WIDTH-1:0] neg_en;
  logic             clr_req;
  logic [WIDTH-1:0] clr_mask;
  logic             clr_ack;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic [WIDTH-1:0] pos_flag;
  logic [WIDTH-1:0] neg_flag;
  logic [WIDTH-1:0] ovf;
  logic             irq;

  modport master (
    output pos, neg, pos_en, neg_en, clr_req, clr_mask, rd_idx,
    input  clr_ack, rd_cnt, pos_flag, neg_flag, ovf, irq
  );

  modport slave (
    input  pos, neg, pos_en, neg_en, clr_req, clr_mask, rd_idx,
    output clr_ack, rd_cnt, pos_flag, neg_flag, ovf, irq
  );
endinterface

// File: rtl/edge_event_capture.sv
// Per-channel sticky edge flags, lost-event tracking and saturating event counters with a clear handshake.
// state | meaning:  IDLE | waiting for an armed clr_req;  ACK | clear applied, clr_ack high for one cycle
module edge_event_capture #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  edge_event_capture_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} clr_state_t;

  clr_state_t       state;
  logic             clr_ack_q;
  logic             clr_armed;
  logic             clr_fire;
  logic [WIDTH-1:0] clr_vec;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pos_flag_q, pos_flag_nxt;
  logic [WIDTH-1:0] neg_flag_q, neg_flag_nxt;
  logic [WIDTH-1:0] ovf_q, ovf_nxt;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [CNT_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_cnt_q;
  logic             irq_q;

  assign rise     = bus.pos & bus.pos_en;
  assign fall     = bus.neg & bus.neg_en;
  // A request held across ACK must drop in IDLE before it can clear again.
  assign clr_fire = (state == IDLE) && bus.clr_req && clr_armed;
  assign clr_vec  = clr_fire ? bus.clr_mask : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clr_ack_q <= 1'b0;
      clr_armed <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_fire) begin
            state     <= ACK;
            clr_ack_q <= 1'b1;
            clr_armed <= 1'b0;
          end else begin
            clr_ack_q <= 1'b0;
            if (!bus.clr_req) clr_armed <= 1'b1;
          end
        end
        ACK: begin
          state     <= IDLE;
          clr_ack_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          clr_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // Set wins over clear; a cleared channel starts from zero so it cannot report a lost event.
  always_comb begin
    logic [CNT_W-1:0] base;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;
    base = '0;
    inc  = '0;
    sum  = '0;
    for (int i = 0; i < WIDTH; i++) cnt_nxt[i] = '0;
    pos_flag_nxt = (pos_flag_q & ~clr_vec) | rise;
    neg_flag_nxt = (neg_flag_q & ~clr_vec) | fall;
    ovf_nxt      = (ovf_q | (rise & pos_flag_q) | (fall & neg_flag_q)) & ~clr_vec;
    for (int i = 0; i < WIDTH; i++) begin
      base       = clr_vec[i] ? '0 : cnt[i];
      inc        = {1'b0, rise[i]} + {1'b0, fall[i]};
      sum        = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
      cnt_nxt[i] = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.rd_idx == IDX_W'(i)) rd_sel = cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_flag_q <= '0;
      neg_flag_q <= '0;
      ovf_q      <= '0;
      rd_cnt_q   <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      pos_flag_q <= pos_flag_nxt;
      neg_flag_q <= neg_flag_nxt;
      ovf_q      <= ovf_nxt;
      rd_cnt_q   <= rd_sel;
      irq_q      <= (|pos_flag_q) | (|neg_flag_q) | (|ovf_q);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign bus.clr_ack  = clr_ack_q;
  assign bus.rd_cnt   = rd_cnt_q;
  assign bus.pos_flag = pos_flag_q;
  assign bus.neg_flag = neg_flag_q;
  assign bus.ovf      = ovf_q;
  assign bus.irq      = irq_q;

endmodule

// File: doc/edge_event_capture.md
EDGE_EVENT_CAPTURE -- requirements
Module: edge_event_capture

Interface
REQ-001 Parameter WIDTH, default 5: number of monitored channels.
REQ-002 Parameter CNT_W, default 8: width of each per-channel event counter.
REQ-003 Parameter IDX_W, default 3: width of rd_idx; SHALL satisfy 2**IDX_W >= WIDTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pos  input  WIDTH  one-cycle rising-edge pulses from the upstream edge detector.
REQ-007 neg  input  WIDTH  one-cycle falling-edge pulses from the upstream edge detector.
REQ-008 pos_en  input  WIDTH  per-channel enable for rising-edge capture.
REQ-009 neg_en  input  WIDTH  per-channel enable for falling-edge capture.
REQ-010 clr_req  input  1  clear request; held high until clr_ack.
REQ-011 clr_mask  input  WIDTH  channels to clear; sampled with clr_req.
REQ-012 clr_ack  output  1  one-cycle clear acknowledge.
REQ-013 rd_idx  input  IDX_W  channel selected for counter readback.
REQ-014 rd_cnt  output  CNT_W  registered event count of channel rd_idx.
REQ-015 pos_flag  output  WIDTH  sticky rising-edge status.
REQ-016 neg_flag  output  WIDTH  sticky falling-edge status.
REQ-017 ovf  output  WIDTH  sticky lost-event status.
REQ-018 irq  output  1  registered interrupt; OR of all pos_flag, neg_flag and ovf bits.

Function
REQ-019 Qualified event: pos[i]&pos_en[i] (rise) or neg[i]&neg_en[i] (fall); disabled pulses SHALL have no effect.
REQ-020 A qualified rise SHALL set pos_flag[i] at the next edge; a qualified fall SHALL set neg_flag[i] likewise.
REQ-021 A qualified rise while pos_flag[i] is already 1, or a qualified fall while neg_flag[i] is already 1, SHALL set ovf[i].
REQ-022 cnt[i] SHALL increment by 1 per cycle with a qualified rise or fall on channel i (both in one cycle: +2), saturating at 2**CNT_W-1 with no wrap.
REQ-023 Saturation SHALL NOT set ovf; ovf reports lost flag events only.
REQ-024 Clear FSM states: IDLE, ACK. IDLE with clr_req=1 -> ACK; ACK drives clr_ack=1 for exactly one cycle -> IDLE.
REQ-025 The clear SHALL take effect on the IDLE->ACK edge: for each i with clr_mask[i]=1, pos_flag[i], neg_flag[i], ovf[i] and cnt[i] go to 0.
REQ-026 Set wins over clear: a qualified event on a cleared channel in the clear cycle SHALL leave its flag at 1 and its count at 1 (or 2 for both edges); ovf[i] SHALL be 0.
REQ-027 clr_req still high in ACK SHALL NOT start a second clear; the next clear needs clr_req low for at least one IDLE cycle.
REQ-028 rd_cnt SHALL equal cnt[rd_idx] as of the previous edge (one-cycle latency); rd_idx >= WIDTH SHALL return 0.
REQ-029 irq SHALL be a register following the flag vectors with one cycle of latency: a rise at edge N sets pos_flag at N+1 and irq at N+2.

Reset
REQ-030 While rst=1, asynchronously: pos_flag, neg_flag, ovf = 0; all counters = 0; rd_cnt = 0; irq = 0; clr_ack = 0; FSM = IDLE.
REQ-031 A reset during ACK SHALL abort the acknowledge; clr_ack SHALL NOT pulse after rst falls.
REQ-032 The first capture after reset release SHALL occur on the first rising clk edge with rst=0.

Verification
REQ-033 pos_en=all 1s, pos[2] pulsed once -> pos_flag=5'b00100, cnt[2]=1, irq=1 two cycles after the pulse edge, ovf=0.
REQ-034 pos[1] pulsed 3 times with no clear -> pos_flag[1]=1, ovf[1]=1, cnt[1]=3; pos_en[1]=0 and one more pulse -> cnt[1] stays 3.
REQ-035 CNT_W=8, 300 qualified rises on channel 0 with periodic clears masking only channel 0's flags... (excluded); instead: 300 rises, no clear -> cnt[0]=255, no wrap, ovf[0]=1.
REQ-036 clr_req with clr_mask=5'b00001 and pos[0] in the same cycle -> clr_ack one cycle later, pos_flag[0]=1, cnt[0]=1, ovf[0]=0.
REQ-037 clr_req held high for 4 cycles -> exactly one clr_ack pulse; channels outside clr_mask unchanged.
REQ-038 rst asserted during ACK with flags set -> all outputs 0 immediately; no clr_ack after release; rd_idx=7 -> rd_cnt=0.
